sweep_bank: RTL
===============

SWEEP_BANK -- requirements
Module: sweep_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent sweep channels (1..8).
REQ-002 SHALL have parameter PERIOD_W, default 11, timer period width (9..16).
REQ-003 SHALL have parameter CARRY_MASK, NUM_CH bits, default 'b01; bit i set = channel i uses ones'-complement negate (extra -1).
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rst_l  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cpu_clk_en  input  1  CPU-rate enable; qualifies register writes.
REQ-007 SHALL have port half_clk_en  input  1  frame-counter half-frame enable; advances all sweep dividers.
REQ-008 SHALL have port wr_en  input  1  register write strobe.
REQ-009 SHALL have port wr_ch  input  $clog2(NUM_CH) (min 1)  target channel.
REQ-010 SHALL have port wr_addr  input  2  0=sweep ctrl, 1=period low, 2=period high, 3=ignored.
REQ-011 SHALL have port wr_data  input  8  write data.
REQ-012 SHALL have port period  output  NUM_CH x PERIOD_W  current timer period per channel.
REQ-013 SHALL have port mute  output  NUM_CH  per-channel mute.
REQ-014 SHALL have port period_update  output  NUM_CH  one-cycle pulse when the sweep rewrites that channel's period.

Function
REQ-015 SHALL accept a write only when wr_en && cpu_clk_en; wr_ch >= NUM_CH or wr_addr=3 SHALL be ignored.
REQ-016 Ctrl write SHALL load enable=wr_data[7], div_period=wr_data[6:4], negate=wr_data[3], shift=wr_data[2:0], and set the channel's reload flag.
REQ-017 Period-low write SHALL replace period[7:0]; period-high write SHALL replace period[PERIOD_W-1:8] with wr_data[PERIOD_W-9:0]; other bits unchanged.
REQ-018 change SHALL be period >> shift (combinational, PERIOD_W bits).
REQ-019 Non-negate: target = period + change in PERIOD_W+1 bits; mute if target exceeds 2^PERIOD_W-1.
REQ-020 Negate: target = period - change - CARRY_MASK[i]; saturate at 0; overflow mute never asserted in negate mode.
REQ-021 mute[i] SHALL also assert whenever period[i] < 8; mute is combinational from current registers, independent of enable.
REQ-022 Each channel SHALL hold a 3-bit divider counter; on half_clk_en: if counter==0 && enable && shift!=0 && !mute, period <= target[PERIOD_W-1:0] and period_update pulses that same cycle.
REQ-023 On the same half_clk_en: if counter==0 or reload set, counter <= div_period and reload <= 0; else counter decrements.
REQ-024 Write and half_clk_en in the same cycle: divider/update SHALL use pre-write values; a period write SHALL win over a sweep update to the same field; a ctrl write SHALL leave reload set.
REQ-025 Channels SHALL be fully independent; a write to one channel SHALL not affect another.
REQ-026 period_update SHALL be 0 in every cycle without half_clk_en.

Reset
REQ-027 While rst_l low, all period, ctrl fields, counters and reload flags SHALL be 0; period_update 0; mute all 1 (period<8).
REQ-028 Reset asserted mid-operation SHALL clear state immediately; first half_clk_en after release with counter 0 SHALL only reload the divider (enable=0).

Structure
REQ-029 Shared apu_pkg SHALL hold the wr_addr enum (SWEEP_CTRL, PERIOD_LO, PERIOD_HI) and the sweep ctrl packed struct (enable, div_period, negate, shift).
REQ-030 Per-channel logic SHALL be sub-module sweep_channel, instantiated NUM_CH times by generate; sweep_bank holds only write decode and output packing.

Verification
REQ-031 Ch0 (CARRY=1) period=0x100, ctrl enable, div 0, negate, shift 1 -> each half_clk_en: 0x100->0x07F->0x03F...; period_update pulses; stops once period<8 (mute=1).
REQ-032 Ch1 (CARRY=0) period=0x100, same ctrl -> 0x100->0x080->0x040; confirms carry difference against ch0.
REQ-033 period=0x600, shift 1, non-negate -> target 0x900, mute=1, period unchanged, no period_update, even with enable=0.
REQ-034 div_period=3 -> updates on every 4th half_clk_en; ctrl rewrite mid-count -> next half_clk_en reloads 3, no update.
REQ-035 Period-low write coincident with an updating half_clk_en -> written value kept, period_update still pulses; ctrl write coincident -> reload flag still set afterward.
REQ-036 Assert rst_l low mid-sweep -> all outputs return to reset values asynchronously; no update on the first post-reset half_clk_en.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU register definitions: write address map and sweep control layout.
package apu_pkg;

  typedef enum logic [1:0] {
    SWEEP_CTRL = 2'd0,
    PERIOD_LO  = 2'd1,
    PERIOD_HI  = 2'd2,
    ADDR_RSVD  = 2'd3
  } wr_addr_e;

  typedef struct packed {
    logic       enable;
    logic [2:0] div_period;
    logic       negate;
    logic [2:0] shift;
  } sweep_ctrl_t;

  localparam int MUTE_MIN_PERIOD = 8;

endpackage

// File: rtl/sweep_channel.sv
// One sweep unit: period register, ctrl fields, divider down-counter and
// the combinational target/mute computation.
module sweep_channel
  import apu_pkg::*;
#(
  parameter int PERIOD_W = 11,
  parameter bit CARRY    = 1'b0
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                half_clk_en,
  input  logic                wr_ctrl,
  input  logic                wr_lo,
  input  logic                wr_hi,
  input  logic [7:0]          wr_data,
  output logic [PERIOD_W-1:0] period,
  output logic                mute,
  output logic                period_update
);

  sweep_ctrl_t         ctrl;
  logic [2:0]          div_cnt;
  logic                reload;
  logic [PERIOD_W-1:0] change;
  logic [PERIOD_W-1:0] target;
  logic [PERIOD_W-1:0] period_nxt;
  logic [PERIOD_W:0]   sum;
  logic [PERIOD_W:0]   diff;
  logic                overflow;

  // A borrow out of diff means the negated target went below zero.
  always_comb begin
    change   = period >> ctrl.shift;
    sum      = {1'b0, period} + {1'b0, change};
    diff     = {1'b0, period} - {1'b0, change} - {{PERIOD_W{1'b0}}, CARRY};
    overflow = !ctrl.negate && sum[PERIOD_W];
    if (ctrl.negate) target = diff[PERIOD_W] ? '0 : diff[PERIOD_W-1:0];
    else             target = sum[PERIOD_W-1:0];
  end

  assign mute          = overflow || (period < PERIOD_W'(MUTE_MIN_PERIOD));
  assign period_update = half_clk_en && (div_cnt == 3'd0) && ctrl.enable &&
                         (ctrl.shift != 3'd0) && !mute;

  // CPU period writes override the sweep result field by field.
  always_comb begin
    period_nxt = period_update ? target : period;
    if (wr_lo) period_nxt[7:0]          = wr_data;
    if (wr_hi) period_nxt[PERIOD_W-1:8] = wr_data[PERIOD_W-9:0];
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      period  <= '0;
      ctrl    <= '0;
      div_cnt <= 3'd0;
      reload  <= 1'b0;
    end else begin
      period <= period_nxt;
      if (half_clk_en) begin
        if ((div_cnt == 3'd0) || reload) begin
          div_cnt <= ctrl.div_period;
          reload  <= 1'b0;
        end else begin
          div_cnt <= div_cnt - 3'd1;
        end
      end
      if (wr_ctrl) begin
        ctrl   <= sweep_ctrl_t'(wr_data);
        reload <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sweep_bank.sv
// Bank of independent sweep channels sharing one CPU write port.
module sweep_bank
  import apu_pkg::*;
#(
  parameter int              NUM_CH     = 2,
  parameter int              PERIOD_W   = 11,
  parameter logic [NUM_CH-1:0] CARRY_MASK = NUM_CH'(1),
  localparam int             CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk,
  input  logic                             rst_l,
  input  logic                             cpu_clk_en,
  input  logic                             half_clk_en,
  input  logic                             wr_en,
  input  logic [CH_W-1:0]                  wr_ch,
  input  logic [1:0]                       wr_addr,
  input  logic [7:0]                       wr_data,
  output logic [NUM_CH-1:0][PERIOD_W-1:0]  period,
  output logic [NUM_CH-1:0]                mute,
  output logic [NUM_CH-1:0]                period_update
);

  wr_addr_e addr;
  logic     wr_ok;

  assign addr  = wr_addr_e'(wr_addr);
  assign wr_ok = wr_en && cpu_clk_en;

  // Out-of-range channel numbers match no instance and fall through.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = wr_ok && (wr_ch == CH_W'(i));

    sweep_channel #(
      .PERIOD_W (PERIOD_W),
      .CARRY    (CARRY_MASK[i])
    ) u_ch (
      .clk           (clk),
      .rst_l         (rst_l),
      .half_clk_en   (half_clk_en),
      .wr_ctrl       (sel && (addr == SWEEP_CTRL)),
      .wr_lo         (sel && (addr == PERIOD_LO)),
      .wr_hi         (sel && (addr == PERIOD_HI)),
      .wr_data       (wr_data),
      .period        (period[i]),
      .mute          (mute[i]),
      .period_update (period_update[i])
    );
  end

endmodule
